// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Drives four board LEDs through one of four blink patterns. A single
// prescaler produces the tick that paces both the pattern steps and the
// button debouncer. A two-state FSM gates everything on the clock manager's
// lock signal (enable). The current FSM state is exposed on fsm_state
// (0 = IDLE, 1 = RUN).
//
// Pattern encoding on mode: 0 BLINK, 1 CHASE, 2 BINARY, 3 BOUNCE.
// There is no valid/ready traffic on this block: every input is a level,
// and every output is a registered level or a one-cycle pulse (tick).

module led_pattern_sequencer #(
    parameter int TICK_DIV       = 320000,
    parameter int TICK_BITS      = 19,
    parameter int STEP_TICKS     = 10,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn,
    output logic       tick,
    output logic [1:0] mode,
    output logic [3:0] led,
    output logic       fsm_state
);

    // Last value of each counter before it wraps or fires.
    localparam logic [TICK_BITS-1:0] PRESC_LAST = TICK_BITS'(TICK_DIV - 1);
    localparam logic [7:0]           STEP_LAST  = 8'(STEP_TICKS - 1);
    localparam logic [3:0]           DEB_LAST   = 4'(DEBOUNCE_TICKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Synchronizer for the asynchronous button input.
    logic btn_meta;
    logic btn_sync;

    // Registered datapath state and its next values.
    logic [TICK_BITS-1:0] presc;
    logic [TICK_BITS-1:0] presc_next;
    logic [7:0]           step_cnt;
    logic [7:0]           step_cnt_next;
    logic [3:0]           deb_cnt;
    logic [3:0]           deb_cnt_next;
    logic                 btn_stable;
    logic                 btn_stable_next;
    logic                 dir_up;
    logic                 dir_up_next;
    logic                 tick_next;
    logic [1:0]           mode_next;
    logic [3:0]           led_next;

    // Per-cycle events derived in the next-state logic.
    logic                 press;
    logic                 step_due;
    logic [1:0]           mode_inc;

    assign mode_inc  = mode + 2'd1;
    assign fsm_state = (state == RUN);

    // Starting LED pattern for each mode.
    function automatic logic [3:0] init_pattern(input logic [1:0] m);
        logic [3:0] p;
        case (m)
            2'd0:    p = 4'b1111;
            2'd1:    p = 4'b0001;
            2'd2:    p = 4'b0000;
            default: p = 4'b0001;
        endcase
        return p;
    endfunction

    // Two-flop synchronizer; runs in every state so it is already settled
    // when the FSM enters RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter, debounce and pattern logic.
    always_comb begin
        state_next      = state;
        presc_next      = presc;
        step_cnt_next   = step_cnt;
        deb_cnt_next    = deb_cnt;
        btn_stable_next = btn_stable;
        dir_up_next     = dir_up;
        tick_next       = 1'b0;
        mode_next       = mode;
        led_next        = led;
        press           = 1'b0;
        step_due        = 1'b0;

        case (state)
            IDLE: begin
                // Counters parked at zero, LEDs dark, button ignored.
                presc_next    = '0;
                step_cnt_next = '0;
                deb_cnt_next  = '0;
                led_next      = 4'b0000;
                if (enable) begin
                    state_next  = RUN;
                    led_next    = init_pattern(mode);
                    dir_up_next = 1'b1;
                end
            end

            RUN: begin
                if (!enable) begin
                    // Lock lost: go dark on this edge, keep mode and the
                    // debounced level, drop any partial debounce count.
                    state_next    = IDLE;
                    presc_next    = '0;
                    step_cnt_next = '0;
                    deb_cnt_next  = '0;
                    led_next      = 4'b0000;
                end else begin
                    presc_next = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                    tick_next  = (presc == PRESC_LAST);

                    if (tick) begin
                        // Debounce: the synced level must disagree with the
                        // stable level on DEBOUNCE_TICKS consecutive ticks.
                        if (btn_sync != btn_stable) begin
                            if (deb_cnt == DEB_LAST) begin
                                btn_stable_next = btn_sync;
                                deb_cnt_next    = '0;
                                press           = btn_sync;
                            end else begin
                                deb_cnt_next = deb_cnt + 4'd1;
                            end
                        end else begin
                            deb_cnt_next = '0;
                        end

                        // Step pacing.
                        if (step_cnt == STEP_LAST) begin
                            step_cnt_next = '0;
                            step_due      = 1'b1;
                        end else begin
                            step_cnt_next = step_cnt + 8'd1;
                        end
                    end

                    if (press) begin
                        // A press overrides a coincident step: the new mode
                        // starts from its initial pattern with a fresh step
                        // count. The prescaler keeps its phase.
                        mode_next     = mode_inc;
                        step_cnt_next = '0;
                        led_next      = init_pattern(mode_inc);
                        dir_up_next   = 1'b1;
                    end else if (step_due) begin
                        case (mode)
                            2'd0: led_next = ~led;
                            2'd1: led_next = {led[2:0], led[3]};
                            2'd2: led_next = led + 4'd1;
                            default: begin
                                // Bounce turns around at either end.
                                if (dir_up) begin
                                    if (led == 4'b1000) begin
                                        led_next    = 4'b0100;
                                        dir_up_next = 1'b0;
                                    end else begin
                                        led_next = {led[2:0], 1'b0};
                                    end
                                end else begin
                                    if (led == 4'b0001) begin
                                        led_next    = 4'b0010;
                                        dir_up_next = 1'b1;
                                    end else begin
                                        led_next = {1'b0, led[3:1]};
                                    end
                                end
                            end
                        endcase
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            step_cnt   <= '0;
            deb_cnt    <= '0;
            btn_stable <= 1'b0;
            dir_up     <= 1'b1;
            tick       <= 1'b0;
            mode       <= 2'd0;
            led        <= 4'b0000;
        end else begin
            presc      <= presc_next;
            step_cnt   <= step_cnt_next;
            deb_cnt    <= deb_cnt_next;
            btn_stable <= btn_stable_next;
            dir_up     <= dir_up_next;
            tick       <= tick_next;
            mode       <= mode_next;
            led        <= led_next;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Directed bench for led_pattern_sequencer with TICK_DIV=4, STEP_TICKS=2,
// DEBOUNCE_TICKS=2. Expected per-cycle output words {state, mode, tick, led}
// are written from hand-derived timelines into exp_q as each stimulus step
// is driven, then popped and compared one per clock on the falling edge.
// Cycle index n counts rising edges since the enable edge (n=0 is that edge).

module tb_led_pattern_sequencer;

    localparam int TICK_DIV       = 4;
    localparam int TICK_BITS      = 3;
    localparam int STEP_TICKS     = 2;
    localparam int DEBOUNCE_TICKS = 2;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       btn;
    logic       tick;
    logic [1:0] mode;
    logic [3:0] led;
    logic       fsm_state;

    int         n_cmp;
    int         n_fail;
    int         n;

    logic [7:0] exp_q[$];

    led_pattern_sequencer #(
        .TICK_DIV       (TICK_DIV),
        .TICK_BITS      (TICK_BITS),
        .STEP_TICKS     (STEP_TICKS),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .btn       (btn),
        .tick      (tick),
        .mode      (mode),
        .led       (led),
        .fsm_state (fsm_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed output word against its expected word.
    task automatic check8(input string tag, input int idx,
                          input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @%0d: observed state=%0d mode=%0d tick=%0d led=%b, expected state=%0d mode=%0d tick=%0d led=%b",
                   tag, idx, obs[7], obs[6:5], obs[4], obs[3:0],
                   expv[7], expv[6:5], expv[4], expv[3:0]);
        end
    endtask

    // Queue the expected words for cycles lo..hi. In RUN a tick is visible
    // after every edge whose index is a positive multiple of TICK_DIV.
    task automatic push_span(input int lo, input int hi, input logic st,
                             input logic [1:0] m, input logic [3:0] l);
        logic t;
        for (int i = lo; i <= hi; i++) begin
            t = st && (i > 0) && ((i % TICK_DIV) == 0);
            exp_q.push_back({st, m, t, l});
        end
    endtask

    // Advance one clock, sample on the falling edge, pop and compare.
    task automatic step_one(input string tag);
        logic [7:0] expv;
        @(negedge clk);
        n++;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s @%0d: observed led=%b with no expected entry queued", tag, n, led);
        end else begin
            expv = exp_q.pop_front();
            check8(tag, n, {fsm_state, mode, tick, led}, expv);
        end
    endtask

    task automatic advance_to(input string tag, input int hi);
        while (n < hi) begin
            step_one(tag);
        end
    endtask

    // Watchdog.
    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: time limit reached at n=%0d, required finish earlier", n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        n      = 0;
        rst    = 1'b1;
        enable = 1'b0;
        btn    = 1'b0;

        // Reset values while rst is held.
        @(negedge clk);
        check8("reset", 0, {fsm_state, mode, tick, led}, 8'h00);
        rst = 1'b0;

        // Disabled for 100 cycles with a noisy button: nothing moves.
        push_span(1, 100, 1'b0, 2'd0, 4'b0000);
        for (int k = 0; k < 100; k++) begin
            btn = 1'($urandom_range(0, 1));
            step_one("idle_noise");
        end
        btn = 1'b0;
        push_span(101, 103, 1'b0, 2'd0, 4'b0000);
        advance_to("idle_noise", 103);

        // Enable in BLINK: 1111 on the enable edge, invert every 8 cycles.
        enable = 1'b1;
        n      = -1;
        push_span(0, 8, 1'b1, 2'd0, 4'b1111);
        push_span(9, 16, 1'b1, 2'd0, 4'b0000);
        push_span(17, 24, 1'b1, 2'd0, 4'b1111);
        push_span(25, 31, 1'b1, 2'd0, 4'b0000);
        advance_to("blink", 31);

        // Hold the button 40 cycles: CHASE is accepted on the edge that
        // would also have stepped BLINK, and the press wins.
        btn = 1'b1;
        push_span(32, 32, 1'b1, 2'd0, 4'b0000);
        push_span(33, 40, 1'b1, 2'd0, 4'b1111);
        push_span(41, 48, 1'b1, 2'd1, 4'b0001);
        push_span(49, 56, 1'b1, 2'd1, 4'b0010);
        push_span(57, 64, 1'b1, 2'd1, 4'b0100);
        push_span(65, 71, 1'b1, 2'd1, 4'b1000);
        advance_to("press_hold", 71);

        // Release: no mode change, chase wraps 1000 -> 0001.
        btn = 1'b0;
        push_span(72, 72, 1'b1, 2'd1, 4'b1000);
        push_span(73, 80, 1'b1, 2'd1, 4'b0001);
        push_span(81, 88, 1'b1, 2'd1, 4'b0010);
        advance_to("release", 88);

        // Three-cycle glitch: shorter than the debounce window.
        btn = 1'b1;
        push_span(89, 91, 1'b1, 2'd1, 4'b0100);
        advance_to("short_pulse", 91);
        btn = 1'b0;
        push_span(92, 96, 1'b1, 2'd1, 4'b0100);
        push_span(97, 104, 1'b1, 2'd1, 4'b1000);
        push_span(105, 112, 1'b1, 2'd1, 4'b0001);
        push_span(113, 120, 1'b1, 2'd1, 4'b0010);
        push_span(121, 124, 1'b1, 2'd1, 4'b0100);
        advance_to("short_pulse", 124);

        // Drop enable at 0100: dark on the next edge, mode kept, button
        // noise ignored while idle.
        enable = 1'b0;
        push_span(125, 130, 1'b0, 2'd1, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            step_one("drop_enable");
            btn = 1'($urandom_range(0, 1));
        end
        btn = 1'b0;
        push_span(131, 136, 1'b0, 2'd1, 4'b0000);
        advance_to("drop_enable", 136);

        // Re-enable: chase restarts from 0001.
        enable = 1'b1;
        n      = -1;
        push_span(0, 8, 1'b1, 2'd1, 4'b0001);
        push_span(9, 16, 1'b1, 2'd1, 4'b0010);
        push_span(17, 20, 1'b1, 2'd1, 4'b0100);
        advance_to("rerun", 20);

        // Press into BINARY, away from a step edge.
        btn = 1'b1;
        push_span(21, 24, 1'b1, 2'd1, 4'b0100);
        push_span(25, 28, 1'b1, 2'd1, 4'b1000);
        push_span(29, 32, 1'b1, 2'd2, 4'b0000);
        advance_to("press_binary", 32);

        // Release, then count 0000..1111 and wrap to 0000.
        btn = 1'b0;
        push_span(33, 36, 1'b1, 2'd2, 4'b0000);
        for (int k = 1; k < 16; k++) begin
            push_span(29 + 8 * k, 36 + 8 * k, 1'b1, 2'd2, 4'(k));
        end
        push_span(157, 160, 1'b1, 2'd2, 4'b0000);
        advance_to("binary", 160);

        // Press into BOUNCE.
        btn = 1'b1;
        push_span(161, 164, 1'b1, 2'd2, 4'b0000);
        push_span(165, 168, 1'b1, 2'd2, 4'b0001);
        push_span(169, 172, 1'b1, 2'd3, 4'b0001);
        advance_to("press_bounce", 172);

        btn = 1'b0;
        push_span(173, 176, 1'b1, 2'd3, 4'b0001);
        push_span(177, 184, 1'b1, 2'd3, 4'b0010);
        push_span(185, 192, 1'b1, 2'd3, 4'b0100);
        push_span(193, 200, 1'b1, 2'd3, 4'b1000);
        push_span(201, 208, 1'b1, 2'd3, 4'b0100);
        push_span(209, 216, 1'b1, 2'd3, 4'b0010);
        push_span(217, 224, 1'b1, 2'd3, 4'b0001);
        push_span(225, 228, 1'b1, 2'd3, 4'b0010);
        advance_to("bounce", 228);

        // From mode 3 one press wraps to BLINK with 1111.
        btn = 1'b1;
        push_span(229, 232, 1'b1, 2'd3, 4'b0010);
        push_span(233, 236, 1'b1, 2'd3, 4'b0100);
        push_span(237, 240, 1'b1, 2'd0, 4'b1111);
        advance_to("wrap", 240);

        btn = 1'b0;
        push_span(241, 244, 1'b1, 2'd0, 4'b1111);
        push_span(245, 252, 1'b1, 2'd0, 4'b0000);
        advance_to("wrap", 252);

        // One more press into CHASE, coinciding with a BLINK step.
        btn = 1'b1;
        push_span(253, 260, 1'b1, 2'd0, 4'b1111);
        push_span(261, 264, 1'b1, 2'd1, 4'b0001);
        advance_to("press_chase", 264);

        // Asynchronous reset between clock edges.
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        btn    = 1'b0;
        #1;
        check8("async_rst", n, {fsm_state, mode, tick, led}, 8'h00);
        @(negedge clk);
        check8("rst_held", n + 1, {fsm_state, mode, tick, led}, 8'h00);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
